clock_set_ctrl: RTL and testbench
=================================

Name: clock_set_ctrl

Overview:
Time-keeping and time-setting controller for the 6-digit HH:MM:SS display.
- Owns the BCD time registers and advances them once per second in RUN mode.
- A 3-button interface (mode/up/down) sequences the SET_HOUR, SET_MIN and SET_SEC modes, freezing and editing the selected field.
- Drives a per-digit blank mask so the digit scanner can blink the field being edited.

Parameters:
CLK_HZ, 1000, clk cycles per second tick (prescaler terminal count + 1)
BLINK_HALF, 250, clk cycles per blink half-period

Ports:
clk  input  1  system clock (1 kHz nominal)
rst  input  1  asynchronous reset, active-low
btn_mode  input  1  mode button, synchronous debounced level, active-high
btn_up  input  1  increment button, synchronous debounced level, active-high
btn_down  input  1  decrement button, synchronous debounced level, active-high
hh_bcd  output  8  hours, BCD {tens,ones}, 00..23
mm_bcd  output  8  minutes, BCD, 00..59
ss_bcd  output  8  seconds, BCD, 00..59
mode  output  2  00 RUN, 01 SET_HOUR, 10 SET_MIN, 11 SET_SEC
blank_mask  output  6  1 = blank digit; [0] sec ones, [1] sec tens, [2] min ones, [3] min tens, [4] hour ones, [5] hour tens
sec_tick  output  1  one-cycle pulse when seconds advance in RUN
day_tick  output  1  one-cycle pulse on 23:59:59 -> 00:00:00 rollover

Behaviour:
- Clock/reset: one clock (clk). rst is asynchronous, active-low. All state is registered.
- Reset values: time 00:00:00, mode RUN, blank_mask 0, sec_tick 0, day_tick 0, prescaler 0, blink counter 0, blink phase 0, button history registers 0.
- Edge detect: each button has a history register; press = level & ~history.
  - A press affects state at the same clk edge that first samples the level as 1.
  - A held button produces exactly one press.
- Mode FSM: RUN -> SET_HOUR -> SET_MIN -> SET_SEC -> RUN, advancing on each mode press.
- RUN:
  - Prescaler counts 0..CLK_HZ-1.
  - At terminal count: prescaler -> 0, seconds +1, sec_tick = 1 for that cycle.
  - Carry chain: ss 59 -> 00 carries to mm; mm 59 -> 00 carries to hh; hh 23 -> 00 asserts day_tick in the same cycle as sec_tick.
  - All carries resolve in one cycle; no intermediate values are visible on the outputs.
  - Up/down presses are ignored.
- SET_* modes:
  - Prescaler is held at 0; time does not advance; sec_tick and day_tick stay 0.
  - Up: selected field +1, wrapping hh 23 -> 00, mm/ss 59 -> 00. No carry into other fields.
  - Down: selected field -1, wrapping 00 -> 23 (hh) or 00 -> 59 (mm/ss).
- Simultaneous presses:
  - Up and down in the same cycle: no change.
  - Mode together with up/down: mode transition only; up/down discarded.
- Leaving SET_SEC to RUN: prescaler starts from 0, so the first sec_tick occurs CLK_HZ cycles after the transition edge.
- Blink:
  - Blink counter runs 0..BLINK_HALF-1; phase toggles at terminal count.
  - Counter and phase clear to 0 on any mode change and on any accepted up/down press, so the edited field is visible immediately.
  - blank_mask = phase replicated onto the two bits of the selected field; other bits 0.
  - In RUN, blank_mask = 0 and the counter is held at 0.
- BCD arithmetic: fields are stored as BCD. Ones digit 9 -> 0 carries to tens; decrement from ones 0 borrows. Illegal BCD never appears on the outputs.
- Reset mid-operation (any mode, any count) returns immediately to the reset values.
- Outputs are registered; hh_bcd/mm_bcd/ss_bcd/mode update at the edge that accepts the event.

Test Plan:
- Reset release with CLK_HZ=4 -> 00:00:00, mode 00, mask 0; sec_tick pulses every 4 cycles; ss reads 01, 02, … after each pulse.
- Preload via SET to 23:59:58, return to RUN, run 2 ticks -> 23:59:59, then 00:00:00 with day_tick and sec_tick both high for that one cycle.
- Mode press once; up held for 10 cycles -> mode 01, hh +1 exactly once. From hh=00: down -> 23; from hh=23: up -> 00; mm unchanged.
- SET_MIN at mm=59, up -> 00 with hh unchanged. SET_SEC at ss=00, down -> 59. Up and down pressed together -> no change.
- BLINK_HALF=3 in SET_MIN -> blank_mask toggles 000000/001100 every 3 cycles; an up press forces 000000 the next cycle and the counter restarts.
- Mode and up in the same cycle while in SET_SEC -> mode 00, ss unchanged, first sec_tick exactly CLK_HZ cycles later. Assert rst low mid-SET_HOUR -> all outputs return to reset values asynchronously.

Source files
------------

// File: rtl/clock_set_ctrl.sv
// HH:MM:SS time-keeping and time-setting controller: BCD time registers,
// one-second advance in RUN, mode/up/down field editing and blink mask generation.
module clock_set_ctrl #(
   parameter int CLK_HZ     = 1000,
   parameter int BLINK_HALF = 250
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       btn_mode,
   input  logic       btn_up,
   input  logic       btn_down,
   output logic [7:0] hh_bcd,
   output logic [7:0] mm_bcd,
   output logic [7:0] ss_bcd,
   output logic [1:0] mode,
   output logic [5:0] blank_mask,
   output logic       sec_tick,
   output logic       day_tick
);

   typedef enum logic [1:0] {
      RUN      = 2'b00,
      SET_HOUR = 2'b01,
      SET_MIN  = 2'b10,
      SET_SEC  = 2'b11
   } mode_e;

   localparam int PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
   localparam int BW = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
   localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_HZ - 1);
   localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_HALF - 1);

   mode_e          state_q, state_d;
   logic [PW-1:0]  presc_q, presc_d;
   logic [BW-1:0]  blink_cnt_q, blink_cnt_d;
   logic           phase_q, phase_d;
   logic           hist_mode_q, hist_up_q, hist_down_q;
   logic [7:0]     hh_d, mm_d, ss_d;
   logic [5:0]     mask_d;
   logic           sec_tick_d, day_tick_d;

   logic           press_mode, press_up, press_down, edit;

   function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] max_v);
      if (v == max_v)         return 8'h00;
      if (v[3:0] == 4'd9)     return {v[7:4] + 4'd1, 4'd0};
      return {v[7:4], v[3:0] + 4'd1};
   endfunction

   function automatic logic [7:0] bcd_dec(input logic [7:0] v, input logic [7:0] max_v);
      if (v == 8'h00)         return max_v;
      if (v[3:0] == 4'd0)     return {v[7:4] - 4'd1, 4'd9};
      return {v[7:4], v[3:0] - 4'd1};
   endfunction

   assign press_mode = btn_mode & ~hist_mode_q;
   assign press_up   = btn_up   & ~hist_up_q;
   assign press_down = btn_down & ~hist_down_q;
   // Mode wins over up/down, and opposing edits cancel out.
   assign edit       = (state_q != RUN) && !press_mode && (press_up ^ press_down);

   always_comb begin
      // NOTE: every variable gets a default first so no path leaves it unassigned (no latches).
      state_d     = state_q;
      presc_d     = presc_q;
      blink_cnt_d = blink_cnt_q;
      phase_d     = phase_q;
      hh_d        = hh_bcd;
      mm_d        = mm_bcd;
      ss_d        = ss_bcd;
      sec_tick_d  = 1'b0;
      day_tick_d  = 1'b0;
      mask_d      = 6'b000000;

      if (press_mode) state_d = mode_e'(state_q + 2'b01);

      case (state_q)
         RUN: begin
            if (presc_q == PRESC_LAST) begin
               presc_d    = '0;
               sec_tick_d = 1'b1;
               ss_d       = bcd_inc(ss_bcd, 8'h59);
               if (ss_bcd == 8'h59) begin
                  mm_d = bcd_inc(mm_bcd, 8'h59);
                  if (mm_bcd == 8'h59) begin
                     hh_d = bcd_inc(hh_bcd, 8'h23);
                     if (hh_bcd == 8'h23) day_tick_d = 1'b1;
                  end
               end
            end else begin
               presc_d = presc_q + PW'(1);
            end
         end
         SET_HOUR: begin
            presc_d = '0;
            if (edit) hh_d = press_up ? bcd_inc(hh_bcd, 8'h23) : bcd_dec(hh_bcd, 8'h23);
         end
         SET_MIN: begin
            presc_d = '0;
            if (edit) mm_d = press_up ? bcd_inc(mm_bcd, 8'h59) : bcd_dec(mm_bcd, 8'h59);
         end
         default: begin
            presc_d = '0;
            if (edit) ss_d = press_up ? bcd_inc(ss_bcd, 8'h59) : bcd_dec(ss_bcd, 8'h59);
         end
      endcase

      // Restart the blink on any edit or mode change so the field shows at once.
      if (state_q == RUN || press_mode || edit) begin
         blink_cnt_d = '0;
         phase_d     = 1'b0;
      end else if (blink_cnt_q == BLINK_LAST) begin
         blink_cnt_d = '0;
         phase_d     = ~phase_q;
      end else begin
         blink_cnt_d = blink_cnt_q + BW'(1);
      end

      case (state_d)
         SET_HOUR: mask_d = {{2{phase_d}}, 4'b0000};
         SET_MIN:  mask_d = {2'b00, {2{phase_d}}, 2'b00};
         SET_SEC:  mask_d = {4'b0000, {2{phase_d}}};
         default:  mask_d = 6'b000000;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= RUN;
         presc_q     <= '0;
         blink_cnt_q <= '0;
         phase_q     <= 1'b0;
         hist_mode_q <= 1'b0;
         hist_up_q   <= 1'b0;
         hist_down_q <= 1'b0;
         hh_bcd      <= 8'h00;
         mm_bcd      <= 8'h00;
         ss_bcd      <= 8'h00;
         blank_mask  <= 6'b000000;
         sec_tick    <= 1'b0;
         day_tick    <= 1'b0;
      end else begin
         state_q     <= state_d;
         presc_q     <= presc_d;
         blink_cnt_q <= blink_cnt_d;
         phase_q     <= phase_d;
         hist_mode_q <= btn_mode;
         hist_up_q   <= btn_up;
         hist_down_q <= btn_down;
         hh_bcd      <= hh_d;
         mm_bcd      <= mm_d;
         ss_bcd      <= ss_d;
         blank_mask  <= mask_d;
         sec_tick    <= sec_tick_d;
         day_tick    <= day_tick_d;
      end
   end

   assign mode = state_q;

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Directed self-checking bench for clock_set_ctrl (CLK_HZ=4, BLINK_HALF=3):
// table of SET-mode button vectors plus hand sequences for ticks, blink and reset.
module tb_clock_set_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic       btn_mode, btn_up, btn_down;
   logic [7:0] hh_bcd, mm_bcd, ss_bcd;
   logic [1:0] mode;
   logic [5:0] blank_mask;
   logic       sec_tick, day_tick;

   int tests  = 0;
   int failed = 0;

   typedef struct {
      logic       m, u, d;
      logic [7:0] hh, mm, ss;
      logic [1:0] md;
   } vec_t;

   vec_t tbl[$];

   clock_set_ctrl #(.CLK_HZ(4), .BLINK_HALF(3)) dut (
      .clk        (clk),
      .rst        (rst),
      .btn_mode   (btn_mode),
      .btn_up     (btn_up),
      .btn_down   (btn_down),
      .hh_bcd     (hh_bcd),
      .mm_bcd     (mm_bcd),
      .ss_bcd     (ss_bcd),
      .mode       (mode),
      .blank_mask (blank_mask),
      .sec_tick   (sec_tick),
      .day_tick   (day_tick)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
      tests++;
      if (act !== exp) begin
         failed++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic add(input logic m, input logic u, input logic d,
                      input logic [7:0] hh, input logic [7:0] mm, input logic [7:0] ss,
                      input logic [1:0] md);
      vec_t v;
      v.m = m; v.u = u; v.d = d; v.hh = hh; v.mm = mm; v.ss = ss; v.md = md;
      tbl.push_back(v);
   endtask

   task automatic check_time(input string name, input logic [7:0] hh, input logic [7:0] mm,
                             input logic [7:0] ss);
      check({name, "_hh"}, hh_bcd, hh);
      check({name, "_mm"}, mm_bcd, mm);
      check({name, "_ss"}, ss_bcd, ss);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1);
   end

   initial begin
      // Starting state 01:00:02 in SET_HOUR, all buttons released.
      add(0,0,1, 8'h00,8'h00,8'h02, 2'd1);
      add(0,0,0, 8'h00,8'h00,8'h02, 2'd1);
      add(0,0,1, 8'h23,8'h00,8'h02, 2'd1);
      add(0,0,0, 8'h23,8'h00,8'h02, 2'd1);
      add(0,1,0, 8'h00,8'h00,8'h02, 2'd1);
      add(0,0,0, 8'h00,8'h00,8'h02, 2'd1);
      add(0,0,1, 8'h23,8'h00,8'h02, 2'd1);
      add(1,0,0, 8'h23,8'h00,8'h02, 2'd2);
      add(0,0,0, 8'h23,8'h00,8'h02, 2'd2);
      add(0,0,1, 8'h23,8'h59,8'h02, 2'd2);
      add(0,0,0, 8'h23,8'h59,8'h02, 2'd2);
      add(0,1,0, 8'h23,8'h00,8'h02, 2'd2);
      add(0,0,0, 8'h23,8'h00,8'h02, 2'd2);
      add(0,0,1, 8'h23,8'h59,8'h02, 2'd2);
      add(1,0,0, 8'h23,8'h59,8'h02, 2'd3);
      add(0,0,0, 8'h23,8'h59,8'h02, 2'd3);
      add(0,0,1, 8'h23,8'h59,8'h01, 2'd3);
      add(0,0,0, 8'h23,8'h59,8'h01, 2'd3);
      add(0,0,1, 8'h23,8'h59,8'h00, 2'd3);
      add(0,0,0, 8'h23,8'h59,8'h00, 2'd3);
      add(0,0,1, 8'h23,8'h59,8'h59, 2'd3);
      add(0,0,0, 8'h23,8'h59,8'h59, 2'd3);
      add(0,1,1, 8'h23,8'h59,8'h59, 2'd3);
      add(0,0,0, 8'h23,8'h59,8'h59, 2'd3);
      add(0,0,1, 8'h23,8'h59,8'h58, 2'd3);
      add(0,0,0, 8'h23,8'h59,8'h58, 2'd3);

      btn_mode = 1'b0; btn_up = 1'b0; btn_down = 1'b0;
      rst = 1'b1;
      #2 rst = 1'b0;
      #1;
      check_time("reset", 8'h00, 8'h00, 8'h00);
      check("reset_mode", 8'(mode), 8'h00);
      check("reset_mask", 8'(blank_mask), 8'h00);
      check("reset_sec_tick", 8'(sec_tick), 8'h00);
      check("reset_day_tick", 8'(day_tick), 8'h00);
      @(posedge clk); @(posedge clk);
      #7 rst = 1'b1;

      // Free-running seconds: one tick every 4 cycles.
      for (int k = 1; k <= 2; k++) begin
         step(3);
         check("run_no_tick", 8'(sec_tick), 8'h00);
         step(1);
         check("run_tick", 8'(sec_tick), 8'h01);
         check("run_ss", ss_bcd, 8'(k));
      end

      // Held up button edits exactly once.
      btn_mode = 1'b1; step(1);
      check("enter_set_hour", 8'(mode), 8'h01);
      btn_mode = 1'b0; btn_up = 1'b1;
      for (int i = 0; i < 10; i++) begin
         step(1);
         check("hold_up_hh", hh_bcd, 8'h01);
      end
      btn_up = 1'b0; step(1);

      for (int i = 0; i < tbl.size(); i++) begin
         btn_mode = tbl[i].m; btn_up = tbl[i].u; btn_down = tbl[i].d;
         step(1);
         check_time($sformatf("vec%0d", i), tbl[i].hh, tbl[i].mm, tbl[i].ss);
         check($sformatf("vec%0d_mode", i), 8'(mode), 8'(tbl[i].md));
      end
      btn_mode = 1'b0; btn_up = 1'b0; btn_down = 1'b0;

      // Back to RUN from 23:59:58, then roll over the day.
      btn_mode = 1'b1; step(1);
      check("to_run_mode", 8'(mode), 8'h00);
      check("to_run_ss", ss_bcd, 8'h58);
      btn_mode = 1'b0;
      step(3);
      check("pre59_tick", 8'(sec_tick), 8'h00);
      step(1);
      check_time("t59", 8'h23, 8'h59, 8'h59);
      check("t59_tick", 8'(sec_tick), 8'h01);
      check("t59_day", 8'(day_tick), 8'h00);
      step(3);
      check("pre_roll_day", 8'(day_tick), 8'h00);
      step(1);
      check_time("roll", 8'h00, 8'h00, 8'h00);
      check("roll_tick", 8'(sec_tick), 8'h01);
      check("roll_day", 8'(day_tick), 8'h01);
      step(1);
      check("post_roll_tick", 8'(sec_tick), 8'h00);
      check("post_roll_day", 8'(day_tick), 8'h00);

      // Blink in SET_MIN.
      btn_mode = 1'b1; step(1);
      check("blink_set_hour", 8'(mode), 8'h01);
      btn_mode = 1'b0; step(1);
      btn_mode = 1'b1; step(1);
      check("blink_set_min", 8'(mode), 8'h02);
      check("blink_e0", 8'(blank_mask), 8'h00);
      btn_mode = 1'b0;
      step(1); check("blink_e1", 8'(blank_mask), 8'h00);
      step(1); check("blink_e2", 8'(blank_mask), 8'h00);
      step(1); check("blink_e3", 8'(blank_mask), 8'h0C);
      step(1); check("blink_e4", 8'(blank_mask), 8'h0C);
      btn_up = 1'b1;
      step(1); check("blink_up_clear", 8'(blank_mask), 8'h00);
      check("blink_up_mm", mm_bcd, 8'h01);
      btn_up = 1'b0;
      step(1); check("blink_e6", 8'(blank_mask), 8'h00);
      step(1); check("blink_e7", 8'(blank_mask), 8'h00);
      step(1); check("blink_e8", 8'(blank_mask), 8'h0C);

      // Mode+up in SET_SEC: mode change only, prescaler restarts.
      btn_mode = 1'b1; step(1);
      check("mu_set_sec", 8'(mode), 8'h03);
      btn_mode = 1'b0; step(1);
      btn_mode = 1'b1; btn_up = 1'b1; step(1);
      check("mu_mode", 8'(mode), 8'h00);
      check_time("mu", 8'h00, 8'h01, 8'h00);
      check("mu_mask", 8'(blank_mask), 8'h00);
      btn_mode = 1'b0; btn_up = 1'b0;
      step(3);
      check("mu_no_tick", 8'(sec_tick), 8'h00);
      step(1);
      check("mu_first_tick", 8'(sec_tick), 8'h01);
      check("mu_first_ss", ss_bcd, 8'h01);

      // Asynchronous reset in the middle of SET_HOUR.
      btn_mode = 1'b1; step(1);
      btn_mode = 1'b0; btn_up = 1'b1; step(1);
      check("rst_pre_hh", hh_bcd, 8'h01);
      btn_up = 1'b0;
      step(3);
      check("rst_pre_mask", 8'(blank_mask), 8'h30);
      #3 rst = 1'b0;
      #1;
      check_time("async_rst", 8'h00, 8'h00, 8'h00);
      check("async_rst_mode", 8'(mode), 8'h00);
      check("async_rst_mask", 8'(blank_mask), 8'h00);
      check("async_rst_tick", 8'(sec_tick), 8'h00);
      check("async_rst_day", 8'(day_tick), 8'h00);
      #10 rst = 1'b1;
      step(2);

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
